// File: rtl/vga_pixel_fetch.sv
// Two-stage VGA pixel fetch: registers the frame-memory address, then the colour and syncs.
// Optional test pattern (vertical colour bars) is built only when VGA_TEST_PATTERN_EN is defined.
module vga_pixel_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        h_active,
  input  logic        v_active,
  input  logic [6:0]  hPixel,
  input  logic [6:0]  vPixel,
  input  logic        test_mode,
  output logic [13:0] vram_addr,
  input  logic [2:0]  vram_data,
  output logic        vga_red,
  output logic        vga_green,
  output logic        vga_blue,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        synced,
  output logic [7:0]  frame_count
);

  typedef enum logic {
    UNSYNCED,
    SYNCED
  } lock_state_t;

  lock_state_t state;

  logic       active_d1;
  logic       hsync_d1;
  logic       vsync_d1;
  logic       vsync_prev;
  logic       vsync_fall;
  logic [2:0] pixel_rgb;

  assign vsync_fall = vsync_prev & ~vsync_in;

`ifdef VGA_TEST_PATTERN_EN
  logic test_mode_d1;

  // vram_addr[6:4] already carries the stage-1 copy of hPixel[6:4], so the bars need no extra register
  always_comb begin
    pixel_rgb = vram_data;
    if (test_mode_d1) pixel_rgb = vram_addr[6:4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) test_mode_d1 <= 1'b0;
    else       test_mode_d1 <= test_mode;
  end
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign pixel_rgb        = vram_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_addr <= 14'd0;
      active_d1 <= 1'b0;
      hsync_d1  <= 1'b1;
      vsync_d1  <= 1'b1;
    end else begin
      vram_addr <= {vPixel, hPixel};
      active_d1 <= h_active & v_active;
      hsync_d1  <= hsync_in;
      vsync_d1  <= vsync_in;
    end
  end

  // Stage 2: vram_data answers the stage-1 address, so it lines up with active_d1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_red   <= 1'b0;
      vga_green <= 1'b0;
      vga_blue  <= 1'b0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      if (active_d1 && synced) begin
        {vga_red, vga_green, vga_blue} <= pixel_rgb;
      end else begin
        {vga_red, vga_green, vga_blue} <= 3'b000;
      end
      vga_hsync <= hsync_d1;
      vga_vsync <= vsync_d1;
    end
  end

  // The locking edge only flips the state; later falling edges count frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= UNSYNCED;
      synced      <= 1'b0;
      frame_count <= 8'd0;
      vsync_prev  <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      case (state)
        UNSYNCED: begin
          if (vsync_fall) begin
            state  <= SYNCED;
            synced <= 1'b1;
          end
        end
        SYNCED: begin
          synced <= 1'b1;
          if (vsync_fall) frame_count <= frame_count + 8'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: random raster stimulus against a per-sample model
// of address, colour, sync delay, lock and frame counting.
module tb_vga_pixel_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in, h_active, v_active, test_mode;
  logic [6:0]  hPixel, vPixel;
  logic [13:0] vram_addr;
  logic [2:0]  vram_data;
  logic        vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, synced;
  logic [7:0]  frame_count;

  vga_pixel_fetch dut (
    .clk(clk), .reset(reset),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .h_active(h_active), .v_active(v_active),
    .hPixel(hPixel), .vPixel(vPixel), .test_mode(test_mode),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .synced(synced), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  logic [2:0] mem [16384];
  assign vram_data = mem[vram_addr];

  typedef struct {
    logic [13:0] addr;
    logic [2:0]  rgb;
    logic        hs;
    logic        vs;
    logic        syn;
    logic [7:0]  fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: the previous sample and the lock/frame bookkeeping
  logic       p_act, p_hs, p_vs, p_tm;
  logic [6:0] p_h, p_v;
  logic       locked;
  logic [7:0] fc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic modelReset();
    p_act = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_tm = 1'b0;
    p_h = 7'd0; p_v = 7'd0;
    locked = 1'b0; fc = 8'd0;
  endtask

  // Drives one sample and queues what the outputs must show after the next rising edge
  task automatic applyStimulus(input logic ha, input logic va, input logic hs, input logic vs,
                               input logic [6:0] h, input logic [6:0] v, input logic tm);
    exp_t e;
    h_active = ha; v_active = va; hsync_in = hs; vsync_in = vs;
    hPixel = h; vPixel = v; test_mode = tm;
    e.addr = {v, h};
    e.hs   = p_hs;
    e.vs   = p_vs;
    e.rgb  = 3'b000;
    if (p_act && locked) begin
      e.rgb = mem[{p_v, p_h}];
`ifdef VGA_TEST_PATTERN_EN
      if (p_tm) e.rgb = p_h[6:4];
`endif
    end
    if (p_vs && !vs) begin
      if (locked) fc = fc + 8'd1;
      else        locked = 1'b1;
    end
    e.syn = locked;
    e.fc  = fc;
    sb.push_back(e);
    p_act = ha & va; p_hs = hs; p_vs = vs; p_tm = tm; p_h = h; p_v = v;
  endtask

  task automatic stepStim(input logic ha, input logic va, input logic hs, input logic vs,
                          input logic [6:0] h, input logic [6:0] v, input logic tm);
    @(negedge clk);
    applyStimulus(ha, va, hs, vs, h, v, tm);
  endtask

  task automatic randomStep(input logic vs);
    stepStim($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, vs,
             7'($urandom_range(0, 127)), 7'($urandom_range(0, 95)), 1'($urandom_range(0, 1)));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_rgb"},    {vga_red, vga_green, vga_blue}, 3'b000);
    checkOutput({tag, "_hsync"},  vga_hsync, 1'b1);
    checkOutput({tag, "_vsync"},  vga_vsync, 1'b1);
    checkOutput({tag, "_addr"},   vram_addr, 14'd0);
    checkOutput({tag, "_synced"}, synced, 1'b0);
    checkOutput({tag, "_fc"},     frame_count, 8'd0);
  endtask

  // Monitor: pops one expectation per rising edge while the pipeline is running
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("vram_addr",   vram_addr, e.addr);
        checkOutput("rgb",         {vga_red, vga_green, vga_blue}, e.rgb);
        checkOutput("vga_hsync",   vga_hsync, e.hs);
        checkOutput("vga_vsync",   vga_vsync, e.vs);
        checkOutput("synced",      synced, e.syn);
        checkOutput("frame_count", frame_count, e.fc);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; h_active = 1'b0; v_active = 1'b0;
    hPixel = 7'd0; vPixel = 7'd0; test_mode = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 3'($urandom_range(0, 7));
    mem[389] = 3'b101;
    mem[{7'd10, 7'd20}] = 3'b111;
    modelReset();
    #12;
    checkResetValues("por");

    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 7'd0, 1'b0);

    $display("[TB] unsynced phase with active pixels");
    for (int i = 0; i < 20; i++)
      stepStim(1'b1, 1'b1, 1'b1, 1'b1, 7'($urandom_range(0, 127)), 7'($urandom_range(0, 95)), 1'b0);

    $display("[TB] lock on vsync falling edge");
    stepStim(1'b1, 1'b1, 1'b1, 1'b0, 7'd1, 7'd1, 1'b0);
    stepStim(1'b1, 1'b1, 1'b1, 1'b1, 7'd2, 7'd1, 1'b0);

    $display("[TB] directed fetch, blanking and test pattern pixels");
    stepStim(1'b1, 1'b1, 1'b1, 1'b1, 7'd5, 7'd3, 1'b0);
    stepStim(1'b1, 1'b0, 1'b1, 1'b1, 7'd20, 7'd10, 1'b0);
    stepStim(1'b1, 1'b1, 1'b1, 1'b1, 7'h35, 7'd4, 1'b1);
    stepStim(1'b1, 1'b1, 1'b1, 1'b1, 7'h36, 7'd4, 1'b1);
    stepStim(1'b0, 1'b1, 1'b0, 1'b1, 7'h37, 7'd4, 1'b0);

    $display("[TB] random raster");
    for (int i = 0; i < 1500; i++) randomStep($urandom_range(0, 39) != 0);

    $display("[TB] asynchronous reset mid-frame");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkResetValues("async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 7'd0, 1'b0);

    $display("[TB] lock then 256 frames");
    stepStim(1'b1, 1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 1'b0);
    for (int f = 0; f < 256; f++) begin
      randomStep(1'b1);
      randomStep(1'b0);
      randomStep(1'b1);
    end
    randomStep(1'b1);
    @(posedge clk);
    #2;
    checkOutput("wrap_frame_count", frame_count, 8'd0);
    checkOutput("wrap_synced", synced, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have port hsync_in, input, 1 bit: horizontal sync from the hsync stage; active-low pulse.
REQ-004 SHALL have port vsync_in, input, 1 bit: vertical sync from the vsync stage; active-low pulse.
REQ-005 SHALL have port h_active, input, 1 bit: horizontal display-active.
REQ-006 SHALL have port v_active, input, 1 bit: vertical display-active.
REQ-007 SHALL have port hPixel, input, 7 bits: column index 0..127.
REQ-008 SHALL have port vPixel, input, 7 bits: row index 0..95.
REQ-009 SHALL have port test_mode, input, 1 bit: selects the test pattern; ignored unless the macro in REQ-028 is defined.
REQ-010 SHALL have port vram_addr, output, 14 bits: frame-memory read address.
REQ-011 SHALL have port vram_data, input, 3 bits: frame-memory read data {R,G,B}, valid exactly one cycle after vram_addr.
REQ-012 SHALL have port vga_red, output, 1 bit: registered red pixel output.
REQ-013 SHALL have port vga_green, output, 1 bit: registered green pixel output.
REQ-014 SHALL have port vga_blue, output, 1 bit: registered blue pixel output.
REQ-015 SHALL have port vga_hsync, output, 1 bit: hsync_in delayed to align with the colour outputs.
REQ-016 SHALL have port vga_vsync, output, 1 bit: vsync_in delayed to align with the colour outputs.
REQ-017 SHALL have port synced, output, 1 bit: high once frame lock is achieved.
REQ-018 SHALL have port frame_count, output, 8 bits: count of completed frames since lock.

Function
REQ-019 SHALL register vram_addr as {vPixel, hPixel} one cycle after the inputs are sampled (pipeline stage 1).
REQ-020 SHALL pipeline active = h_active AND v_active, hsync_in and vsync_in through 2 register stages, so all outputs share a latency of exactly 2 cycles from input sampling.
REQ-021 SHALL drive colour outputs in stage 2 as follows:
  - vram_data, when the delayed active bit is 1 and synced is 1;
  - 3'b000 otherwise (blanking, porches, unlocked).
REQ-022 SHALL implement a lock FSM with two states:
  - UNSYNCED, entered on reset;
  - SYNCED, entered when a vsync_in falling edge is detected (registered previous value 1, current value 0);
  - SYNCED SHALL persist until reset.
REQ-023 SHALL assert synced only in state SYNCED; synced SHALL rise the cycle after the detecting edge.
REQ-024 SHALL increment frame_count by 1 on each vsync_in falling edge while in SYNCED (excluding the locking edge), wrapping from 255 to 0.
REQ-025 SHALL drive vga_hsync and vga_vsync from the delay pipeline regardless of lock state.
REQ-026 SHALL, when active deasserts mid-line, blank exactly those pixels whose delayed active bit is 0, with no extra cycles of colour.

Reset
REQ-027 SHALL, on reset, set the following values asynchronously; the first pipeline outputs are valid 2 cycles after reset deasserts:
  - colour outputs 0;
  - vga_hsync and vga_vsync 1 (inactive), with all pipeline sync registers set to 1;
  - vram_addr 0;
  - synced 0 and FSM in UNSYNCED;
  - frame_count 0;
  - edge-detect register 1.

Configuration
REQ-028 SHALL compile in the test pattern only when VGA_TEST_PATTERN_EN is defined.
  - Defined, with test_mode 1 and synced 1: during active pixels, colour is {R,G,B} = hPixel[6:4] of the pixel, delayed 2 cycles (8 vertical bars of 16 columns); vram_data is ignored.
  - Not defined: test_mode has no effect and no pattern logic exists.

Verification
REQ-029 SHALL show that reset is asynchronous: assert reset mid-frame -> on that edge, all outputs take REQ-027 values and synced=0 without waiting for clk.
REQ-030 SHALL show lock: vsync_in 1->0 at cycle N -> synced=1 at N+1, frame_count=0; next falling edge -> frame_count=1.
REQ-031 SHALL show fetch latency: hPixel=5, vPixel=3, both actives 1, vram returning 3'b101 -> vram_addr=14'd389 one cycle later; vga_red/green/blue=1/0/1 two cycles after input.
REQ-032 SHALL show blanking: v_active=0 with vram_data=3'b111 -> colour outputs 000; also 000 while UNSYNCED with both actives 1.
REQ-033 SHALL show frame-count wrap: 256 frames after lock -> frame_count returns to 0, and synced stays 1.
REQ-034 SHALL show the test pattern: with VGA_TEST_PATTERN_EN defined, test_mode=1, hPixel=0x35 active -> colour 3'b011 two cycles later.
